// File: rtl/fp_pkg.sv
// fp_pkg: shared FP writeback defaults, source-select encoding and helpers
package fp_pkg;
   localparam int FP_WIDTH = 32;
   localparam int FP_DEPTH = 5;
   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;
   function automatic logic [2**FP_DEPTH-1:0] rd_mask(input logic en, input logic [FP_DEPTH-1:0] rd);
      rd_mask = '0;
      rd_mask[rd] = en;
   endfunction
endpackage

// File: rtl/fp_wb_ctrl_if.sv
// fp_wb_ctrl_if: issue, result-source and register-file write signals of the FP writeback controller
interface fp_wb_ctrl_if import fp_pkg::*; #(
   parameter int WIDTH = FP_WIDTH,
   parameter int DEPTH = FP_DEPTH
);
   logic                  issue_valid;
   logic [DEPTH-1:0]      issue_rd;
   logic                  issue_ready;
   logic [2**DEPTH-1:0]   busy;
   logic                  a_valid;
   logic                  a_ready;
   logic [DEPTH-1:0]      a_rd;
   logic [WIDTH-1:0]      a_data;
   logic                  b_valid;
   logic                  b_ready;
   logic [DEPTH-1:0]      b_rd;
   logic [WIDTH-1:0]      b_data;
   logic                  we;
   logic [DEPTH-1:0]      wa;
   logic [WIDTH-1:0]      wd;
   logic                  wb_err;
   modport master (
      output issue_valid, issue_rd, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  issue_ready, busy, a_ready, b_ready, we, wa, wd, wb_err
   );
   modport slave (
      input  issue_valid, issue_rd, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output issue_ready, busy, a_ready, b_ready, we, wa, wd, wb_err
   );
endinterface

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: per-register pending-write bits; a same-edge set beats a clear
module fp_scoreboard import fp_pkg::*; #(
   parameter int DEPTH = FP_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set,
   input  logic [DEPTH-1:0]    set_rd,
   input  logic                clr,
   input  logic [DEPTH-1:0]    clr_rd,
   output logic [2**DEPTH-1:0] busy
);
   logic [2**DEPTH-1:0] set_m, clr_m;
   always_comb begin
      set_m = '0;
      clr_m = '0;
      set_m[set_rd] = set;
      clr_m[clr_rd] = clr;
   end
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= (busy & ~clr_m) | set_m;
   end
endmodule

// File: rtl/fp_wb_ctrl.sv
// fp_wb_ctrl: round-robin arbitration of two FP result sources onto one register-file write port,
// with a WAW scoreboard gating issue and a sticky error for writes to non-pending registers
module fp_wb_ctrl import fp_pkg::*; #(
   parameter int WIDTH = FP_WIDTH,
   parameter int DEPTH = FP_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   fp_wb_ctrl_if.slave bus
);
   logic [2**DEPTH-1:0] busy;
   src_t                last, sel;
   logic                acc, issue_fire;
   logic [DEPTH-1:0]    acc_rd, wa_q;
   logic [WIDTH-1:0]    acc_data, wd_q;
   logic                we_q, err_q;
   always_comb begin
      bus.a_ready = bus.a_valid & (~bus.b_valid | (last == SRC_B));
      bus.b_ready = bus.b_valid & (~bus.a_valid | (last == SRC_A));
      acc         = bus.a_ready | bus.b_ready;
      sel         = bus.b_ready ? SRC_B : SRC_A;
      acc_rd      = (sel == SRC_B) ? bus.b_rd : bus.a_rd;
      acc_data    = (sel == SRC_B) ? bus.b_data : bus.a_data;
      bus.issue_ready = ~busy[bus.issue_rd];
      issue_fire  = bus.issue_valid & bus.issue_ready;
   end
   fp_scoreboard #(.DEPTH(DEPTH)) u_sb (
      .clk    (clk),
      .rst    (rst),
      .set    (issue_fire),
      .set_rd (bus.issue_rd),
      .clr    (acc),
      .clr_rd (acc_rd),
      .busy   (busy)
   );
   // last starts at SRC_B so A wins the first contention after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q  <= 1'b0;
         wa_q  <= '0;
         wd_q  <= '0;
         err_q <= 1'b0;
         last  <= SRC_B;
      end else begin
         we_q  <= acc;
         err_q <= err_q | (acc & ~busy[acc_rd]);
         if (acc) begin
            wa_q <= acc_rd;
            wd_q <= acc_data;
            last <= sel;
         end
      end
   end
   assign bus.busy   = busy;
   assign bus.we     = we_q;
   assign bus.wa     = wa_q;
   assign bus.wd     = wd_q;
   assign bus.wb_err = err_q;
endmodule

// File: tb/tb_fp_wb_ctrl.sv
// tb_fp_wb_ctrl: table-driven directed checks of fp_wb_ctrl plus hand-written lone-source sequences
module tb_fp_wb_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass = 0;
   int   total = 0;
   always #5 clk = ~clk;
   fp_wb_ctrl_if #(.WIDTH(32), .DEPTH(5)) bus ();
   fp_wb_ctrl #(.WIDTH(32), .DEPTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic        rst, iv;
      logic [4:0]  ird;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  brd;
      logic [31:0] bd;
      logic        ar, br, ir, we;
      logic [4:0]  wa;
      logic [31:0] wd, busy;
      logic        err;
   } vec_t;
   vec_t tbl[$];
   task automatic add(input logic r, iv, input logic [4:0] ird, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                      input logic ar, br, ir, we, input logic [4:0] wa, input logic [31:0] wd, busy,
                      input logic err);
      vec_t v;
      v.rst = r; v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.ad = ad;
      v.bv = bv; v.brd = brd; v.bd = bd; v.ar = ar; v.br = br; v.ir = ir;
      v.we = we; v.wa = wa; v.wd = wd; v.busy = busy; v.err = err;
      tbl.push_back(v);
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   task automatic drive(input logic r, iv, input logic [4:0] ird, input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic bv, input logic [4:0] brd, input logic [31:0] bd);
      rst = r; bus.issue_valid = iv; bus.issue_rd = ird;
      bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad;
      bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bd;
   endtask
   task automatic post(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] busy, input logic err);
      @(posedge clk); #1;
      chk({tag, " we"}, 32'(bus.we), 32'(we));
      chk({tag, " wa"}, 32'(bus.wa), 32'(wa));
      chk({tag, " wd"}, bus.wd, wd);
      chk({tag, " busy"}, bus.busy, busy);
      chk({tag, " wb_err"}, 32'(bus.wb_err), 32'(err));
   endtask
   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset we", 32'(bus.we), 0);
      chk("reset wa", 32'(bus.wa), 0);
      chk("reset wd", bus.wd, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset wb_err", 32'(bus.wb_err), 0);
      //  rst iv ird av ard ad           bv brd bd           ar br ir we wa wd           busy         err
      add(0, 1, 3, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h8,       0);
      add(0, 1, 3, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0,            32'h8,       0);
      add(0, 0, 3, 1, 3, 32'h3F800000, 0, 0, 0,            1, 0, 0, 1, 3, 32'h3F800000, 32'h0,       0);
      add(0, 0, 3, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 3, 32'h3F800000, 32'h0,       0);
      add(1, 0, 0, 1, 9, 32'h11111111, 0, 0, 0,            1, 0, 1, 0, 0, 0,            32'h0,       0);
      add(0, 1, 1, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h2,       0);
      add(0, 1, 2, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h6,       0);
      add(0, 0, 0, 1, 1, 32'hA1,       1, 2, 32'hB2,       1, 0, 1, 1, 1, 32'hA1,       32'h4,       0);
      add(0, 0, 0, 1, 1, 32'hA1,       1, 2, 32'hB2,       0, 1, 1, 1, 2, 32'hB2,       32'h0,       0);
      add(0, 0, 0, 1, 1, 32'hA1,       1, 2, 32'hB2,       1, 0, 1, 1, 1, 32'hA1,       32'h0,       1);
      add(0, 0, 0, 1, 1, 32'hA1,       1, 2, 32'hB2,       0, 1, 1, 1, 2, 32'hB2,       32'h0,       1);
      add(0, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 2, 32'hB2,       32'h0,       1);
      add(1, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h0,       0);
      add(0, 1, 5, 0, 0, 0,            1, 5, 32'h55,       0, 1, 1, 1, 5, 32'h55,       32'h20,      1);
      add(0, 0, 0, 1, 7, 32'h77,       0, 0, 0,            1, 0, 1, 1, 7, 32'h77,       32'h20,      1);
      add(1, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h0,       0);
      add(0, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h0,       0);
      add(1, 1, 4, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h0,       0);
      add(0, 0, 4, 0, 0, 0,            0, 0, 0,            0, 0, 1, 0, 0, 0,            32'h0,       0);
      foreach (tbl[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].iv, tbl[i].ird, tbl[i].av, tbl[i].ard, tbl[i].ad,
               tbl[i].bv, tbl[i].brd, tbl[i].bd);
         #1;
         chk({tag, " a_ready"}, 32'(bus.a_ready), 32'(tbl[i].ar));
         chk({tag, " b_ready"}, 32'(bus.b_ready), 32'(tbl[i].br));
         chk({tag, " issue_ready"}, 32'(bus.issue_ready), 32'(tbl[i].ir));
         post(tag, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].busy, tbl[i].err);
      end
      // register 0 is writable, and a lone B is granted back-to-back despite having won last
      @(negedge clk);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      post("issue r0", 0, 0, 0, 32'h1, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 1, 5'(k * 6), 32'hDEAD0000 + k);
         #1;
         chk($sformatf("lone b%0d b_ready", k), 32'(bus.b_ready), 1);
         chk($sformatf("lone b%0d a_ready", k), 32'(bus.a_ready), 0);
         post($sformatf("lone b%0d", k), 1, 5'(k * 6), 32'hDEAD0000 + k, 32'h0, k != 0);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      post("idle hold", 0, 12, 32'hDEAD0002, 32'h0, 1);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/fp_wb_ctrl.md
FP_WB_CTRL -- requirements
Module: fp_wb_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, FP data width.
REQ-002 Parameter DEPTH, default 5, register address width (32 FP registers).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 issue_valid  in  1  decode issues an FP op whose destination is issue_rd.
REQ-007 issue_rd  in  DEPTH  destination register of the issued op.
REQ-008 issue_ready  out  1  high when issue_rd is not pending.
REQ-009 busy  out  32  per-register pending-write scoreboard.
REQ-010 a_valid / a_ready / a_rd / a_data  in / out / in DEPTH / in WIDTH  source A result (fadd/fmul pipe).
REQ-011 b_valid / b_ready / b_rd / b_data  in / out / in DEPTH / in WIDTH  source B result (fdiv/fsqrt unit).
REQ-012 we / wa / wd  out / out DEPTH / out WIDTH  FP register-file write port; connects directly to the file's we/wa/wd.
REQ-013 wb_err  out  1  sticky error: result written to a register that was not pending.

Function
REQ-014 The block shall accept at most one result per cycle; a_ready and b_ready shall be combinational grants and never both high.
REQ-015 A source is accepted when its valid and ready are both high; with no contention, the sole valid source shall be granted.
REQ-016 When both are valid, the grant shall go to the source not accepted most recently (1-bit round-robin state last_b, updated only on acceptance).
REQ-017 Latency: one cycle; in the cycle after acceptance, we=1, wa=accepted rd, wd=accepted data; otherwise we=0, with wa/wd holding their last values.
REQ-018 The block shall apply no backpressure beyond arbitration: a lone valid source shall always be accepted in the same cycle.
REQ-019 Register 0 is an ordinary writable FP register, not hardwired.
REQ-020 On an issue_valid & issue_ready edge, busy[issue_rd] shall be set.
REQ-021 On an acceptance edge, busy[rd] shall be cleared; busy therefore drops in the same cycle we asserts, and the register file's write-forwarding supplies the value.
REQ-022 If an issue and an acceptance target the same register on one edge, set shall win (busy stays 1).
REQ-023 issue_ready shall equal ~busy[issue_rd] (registered scoreboard value, no same-cycle bypass); decode stalls on WAW.
REQ-024 Accepting a result whose rd has busy=0 shall still perform the write and shall set wb_err, which holds until reset.
REQ-025 Sources shall hold valid/rd/data stable until accepted; the block shall not check this.

Reset
REQ-026 On reset: we=0, wa=0, wd=0, busy=0, wb_err=0, last_b=1 (A wins first contention).
REQ-027 Reset shall override any same-edge issue or acceptance; an in-flight output write in the reset cycle shall be dropped (we=0 next cycle).

Structure
REQ-028 WIDTH/DEPTH defaults and the source-select encoding (SRC_A=0, SRC_B=1) shall live in shared package fp_pkg.
REQ-029 The scoreboard shall be a natural sub-module, fp_scoreboard (set/clear ports, busy vector out); arbitration and output register shall stay in fp_wb_ctrl.

Verification
REQ-030 Reset, then issue rd=3 -> busy=0x00000008 next cycle; issue_ready low for issue_rd=3.
REQ-031 a_valid, a_rd=3, a_data=0x3F800000 alone -> a_ready=1; next cycle we=1, wa=3, wd=0x3F800000, busy[3]=0.
REQ-032 Both valid for 4 cycles (a_rd=1, b_rd=2, both pending) after reset -> grants A,B,A,B; writes rd 1,2,1,2 one cycle later; second writes set wb_err.
REQ-033 Same edge: issue rd=5 while B result for rd=5 is accepted -> we=1, wa=5 next cycle and busy[5] remains 1.
REQ-034 Result accepted to rd=7 with busy[7]=0 -> write occurs and wb_err=1, held until rst.
REQ-035 rst asserted in the cycle after an acceptance -> we=0, busy=0, wb_err=0 the following cycle.
